// File: rtl/noc_tgt_pkg.sv
// Shared types and field positions for the NoC target responder.
package noc_tgt_pkg;

  localparam int RSP_TID_W  = 6;
  localparam int RSP_DEST_W = 5;

  localparam int OP_BIT   = 31;
  localparam int ERR_BIT  = 30;
  localparam int ADDR_MSB = 30;
  localparam int ADDR_LSB = 24;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

  localparam logic [6:0] STAT_ADDR = 7'h7F;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  typedef struct packed {
    op_e                   op;
    logic                  err;
    logic [15:0]           rdata;
    logic [RSP_TID_W-1:0]  tid;
    logic [RSP_DEST_W-1:0] dest;
  } rsp_entry_t;

endpackage

// File: rtl/noc_tgt_rsp_fifo.sv
// Synchronous response FIFO of rsp_entry_t; DEPTH must be a power of 2 so the
// pointers wrap naturally.
module noc_tgt_rsp_fifo
  import noc_tgt_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  rsp_entry_t din_i,
  input  logic       pop_i,
  output rsp_entry_t dout_o,
  output logic [AW:0] count_o,
  output logic       full_o,
  output logic       empty_o
);

  rsp_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_pop;

  assign do_pop  = pop_i && !empty_o;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  // Upstream admission control guarantees a free slot for every push.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_i && full_o));

endmodule

// File: rtl/noc_tgt_responder.sv
// Single-beat NoC target: executes read/write requests on a local 16-bit memory
// and returns one response per request. Optional counter via NOC_TGT_STAT_EN.
module noc_tgt_responder
  import noc_tgt_pkg::*;
#(
  parameter int NODE_ID   = 0,
  parameter int MEM_DEPTH = 32,
  parameter int RSP_DEPTH = 4,
  parameter int TDATA_W   = 32,
  parameter int TID_W     = RSP_TID_W,
  parameter int TDEST_W   = RSP_DEST_W,
  parameter int TUSER_W   = RSP_DEST_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_tvalid,
  output logic               req_tready,
  input  logic [TDATA_W-1:0] req_tdata,
  input  logic [TID_W-1:0]   req_tid,
  input  logic [TDEST_W-1:0] req_tdest,
  input  logic [TUSER_W-1:0] req_tuser,
  input  logic [3:0]         req_tstrb,
  input  logic [3:0]         req_tkeep,
  input  logic               req_tlast,
  output logic               rsp_tvalid,
  input  logic               rsp_tready,
  output logic [TDATA_W-1:0] rsp_tdata,
  output logic [TID_W-1:0]   rsp_tid,
  output logic [TDEST_W-1:0] rsp_tdest,
  output logic [TUSER_W-1:0] rsp_tuser,
  output logic [3:0]         rsp_tstrb,
  output logic [3:0]         rsp_tkeep,
  output logic               rsp_tlast
);

  localparam int MAW = $clog2(MEM_DEPTH);
  localparam int CW  = $clog2(RSP_DEPTH) + 1;

  logic [15:0]    mem_q [MEM_DEPTH];
  rsp_entry_t     stage_q, stage_d;
  logic           stage_vld_q;
  rsp_entry_t     fifo_dout;
  logic [CW-1:0]  fifo_count;
  logic           fifo_full, fifo_empty, rsp_pop;

  logic           accept, req_wr, in_range, misrouted, is_stat, req_err, mem_we;
  logic [6:0]     req_addr;
  logic [15:0]    req_wdata, stat_val;
  logic [MAW-1:0] mem_idx;
  logic           unused_inputs;

  assign req_wr    = req_tdata[OP_BIT];
  assign req_addr  = req_tdata[ADDR_MSB:ADDR_LSB];
  assign req_wdata = req_tdata[DATA_MSB:DATA_LSB];
  assign mem_idx   = req_addr[MAW-1:0];
  assign in_range  = ({25'd0, req_addr} < 32'(MEM_DEPTH));
  assign misrouted = (req_tdest != TDEST_W'(NODE_ID));
  assign req_err   = misrouted || (!in_range && !is_stat);
  assign mem_we    = accept && req_wr && !req_err && !is_stat;

  // Both sides use strict valid/ready: a beat transfers on the cycle valid and
  // ready are high together; a raised valid and its fields hold until then.
  // Admission counts stage + FIFO as of this cycle, so a pop frees a slot only
  // on the following cycle and nothing combinational reaches from rsp_tready.
  assign req_tready = !rst &&
    (({1'b0, fifo_count} + {{CW{1'b0}}, stage_vld_q}) < (CW+1)'(RSP_DEPTH));
  assign accept     = req_tvalid && req_tready;

`ifdef NOC_TGT_STAT_EN
  logic [15:0] stat_q, stat_d;

  assign is_stat  = (req_addr == STAT_ADDR);
  assign stat_val = stat_q;

  // A read of the counter reports the pre-request value and is itself counted.
  always_comb begin
    stat_d = stat_q;
    if (accept && !req_err) begin
      if (is_stat && req_wr)        stat_d = '0;
      else if (stat_q != 16'hFFFF)  stat_d = stat_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stat_q <= '0;
    else     stat_q <= stat_d;
  end
`else
  assign is_stat  = 1'b0;
  assign stat_val = 16'd0;
`endif

  always_comb begin
    stage_d       = '0;
    stage_d.op    = req_wr ? OP_WR : OP_RD;
    stage_d.err   = req_err;
    stage_d.tid   = req_tid;
    stage_d.dest  = req_tuser;
    if (!req_err && !req_wr) stage_d.rdata = is_stat ? stat_val : mem_q[mem_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_vld_q <= 1'b0;
      stage_q     <= '0;
    end else begin
      stage_vld_q <= accept;
      if (accept) stage_q <= stage_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= req_wdata;
  end

  assign rsp_pop = rsp_tvalid && rsp_tready;

  noc_tgt_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (stage_vld_q),
    .din_i   (stage_q),
    .pop_i   (rsp_pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rsp_tvalid = !fifo_empty;
  assign rsp_tstrb  = 4'hF;
  assign rsp_tkeep  = 4'hF;
  assign rsp_tlast  = 1'b1;

  always_comb begin
    rsp_tdata = '0;
    rsp_tid   = '0;
    rsp_tdest = '0;
    rsp_tuser = '0;
    if (rsp_tvalid) begin
      rsp_tdata[OP_BIT]            = fifo_dout.op;
      rsp_tdata[ERR_BIT]           = fifo_dout.err;
      rsp_tdata[DATA_MSB:DATA_LSB] = fifo_dout.rdata;
      rsp_tid                      = fifo_dout.tid;
      rsp_tdest                    = fifo_dout.dest;
      rsp_tuser                    = TUSER_W'(NODE_ID);
    end
  end

  assign unused_inputs = ^{req_tstrb, req_tkeep, req_tlast, req_tdata[23:16], fifo_full};

endmodule
